pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and memory-wait controller for a 5-stage MIPS pipeline.
// Shadows the EX/MEM destination records to drive forwarding, load-use stalls and memory freezes.
//
// state | meaning
// RUN   | pipe advancing normally; a pending data-memory access that is not ready freezes and enters WAIT
// WAIT  | pipe frozen until dmem_ready, bounded by the watchdog timer
// ERR   | watchdog expired; one unfrozen cycle drops the failed access
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wmem,
  input  logic [4:0]       id_rn,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] rn;
  } rec_t;

  // Down-counter holds the remaining WAIT cycles before expiry; MEM_TIMEOUT must be >= 2.
  localparam int            TW       = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(MEM_TIMEOUT - 2);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_d;
  rec_t          ex_q, mem_q, id_rec;
  logic          stall;
  logic          mem_acc;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input rec_t ex, input rec_t mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.wreg && ex.rn != 5'd0 && ex.rn == src && !ex.m2reg)
      sel = 2'b01;
    else if (mem.wreg && mem.rn != 5'd0 && mem.rn == src)
      sel = mem.m2reg ? 2'b11 : 2'b10;
    return sel;
  endfunction

  assign id_rec  = '{wreg: id_wreg, m2reg: id_m2reg, wmem: id_wmem, rn: id_rn};
  assign mem_acc = mem_q.m2reg | mem_q.wmem;

  assign fwda = fwd_sel(id_rs, ex_q, mem_q);
  assign fwdb = fwd_sel(id_rt, ex_q, mem_q);

  assign stall = id_valid & ex_q.wreg & ex_q.m2reg & (ex_q.rn != 5'd0) &
                 ((id_use_rs & (ex_q.rn == id_rs)) | (id_use_rt & (ex_q.rn == id_rt)));

  assign wpcir  = ~stall & ~freeze;
  assign bubble = stall & ~freeze;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    err_d   = mem_err;
    freeze  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_acc && !dmem_ready && !mem_err) begin
          freeze  = 1'b1;
          state_d = S_WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end else begin
          freeze = 1'b1;
          if (tmr_q == '0) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      S_ERR: begin
        state_d = S_RUN;
        tmr_d   = '0;
      end
      default: begin
        state_d = S_RUN;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      tmr_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      mem_err <= err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!freeze) begin
      mem_q <= ex_q;
      ex_q  <= (id_valid && !stall) ? id_rec : '0;
    end
  end

  // Counts every cycle the front end is held, frozen or stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (cnt_clr)
      stall_cnt <= '0;
    else if (!wpcir && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
